ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide engine for the execute stage
//
// Purpose: computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands.
//   Multiply retires MUL_BPC multiplier bits per cycle, divide retires DIV_BPC
//   quotient bits per cycle (restoring). Divide-by-zero and signed overflow
//   complete in one cycle. flush_i aborts any operation in flight.
// Optional: define MULDIV_RESULT_REUSE_EN to keep the last full product or
//   quotient+remainder so a paired op on identical operands completes in one cycle.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, op_i[2:0]    request and opcode (0 MUL .. 7 REMU), taken when ready_o
//   a_i, b_i [XLEN-1:0]   rs1 / rs2 operands, latched on accept
//   flush_i               abort, highest priority
//   ready_o               idle
//   stall_o               execute stage must hold
//   valid_o, result_o     one-cycle result pulse, registered result
module ex_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 4,
  parameter int DIV_BPC = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BPC - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN / DIV_BPC - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          op_q;      // op[2] is implied by the MUL/DIV state
  logic                a_neg_q, b_neg_q;
  logic [XLEN-1:0]     a_q, b_q;  // magnitudes: multiplicand / divisor
  logic [2*XLEN-1:0]   prod_q;    // MUL: {partial, multiplier}; DIV: {remainder, dividend->quotient}
  logic [XLEN-1:0]     result_q;
  logic                valid_q;

  // Accept-cycle decode. MUL is treated as signed x signed; its low half is
  // identical for every signedness, which also lets it share cached products.
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic [2:0]      cls;

  always_comb begin
    is_div   = op_i[2];
    a_sgn    = is_div ? ~op_i[0] : (op_i[1:0] != 2'd3);
    b_sgn    = is_div ? ~op_i[0] : (op_i[1:0] <= 2'd1);
    a_neg    = a_sgn & a_i[XLEN-1];
    b_neg    = b_sgn & b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    cls      = {is_div, a_sgn, b_sgn};
    div0     = is_div && (b_i == '0);
    ovf      = is_div && !op_i[0] && (a_i == MOST_NEG) && (b_i == '1);
    fast     = div0 || ovf;
    fast_res = '0;
    if (div0)     fast_res = op_i[1] ? a_i : '1;
    else if (ovf) fast_res = op_i[1] ? '0 : a_i;
  end

  // Multiply step: add a * (next MUL_BPC multiplier bits) into the upper half,
  // then shift the whole product register right by MUL_BPC.
  logic [XLEN+MUL_BPC-1:0]   mul_sum;
  logic [2*XLEN+MUL_BPC-1:0] mul_cat;
  logic [2*XLEN-1:0]         mul_prod_d, mul_fin;
  logic [XLEN-1:0]           mul_res;

  always_comb begin
    mul_sum    = {{MUL_BPC{1'b0}}, prod_q[2*XLEN-1:XLEN]} +
                 ({{MUL_BPC{1'b0}}, a_q} * {{XLEN{1'b0}}, prod_q[MUL_BPC-1:0]});
    mul_cat    = {mul_sum, prod_q[XLEN-1:0]} >> MUL_BPC;
    mul_prod_d = mul_cat[2*XLEN-1:0];
    mul_fin    = (a_neg_q ^ b_neg_q) ? -mul_prod_d : mul_prod_d;
    mul_res    = (op_q == 2'd0) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
  end

  // Restoring divide, DIV_BPC quotient bits per cycle.
  logic [XLEN-1:0] div_r, div_q, quo_s, rem_s, div_res;
  logic [XLEN:0]   div_trial;

  always_comb begin
    div_r     = prod_q[2*XLEN-1:XLEN];
    div_q     = prod_q[XLEN-1:0];
    div_trial = '0;
    for (int i = 0; i < DIV_BPC; i++) begin
      div_trial = {div_r, div_q[XLEN-1]} - {1'b0, b_q};
      if (!div_trial[XLEN]) div_r = div_trial[XLEN-1:0];
      else                  div_r = {div_r[XLEN-2:0], div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], ~div_trial[XLEN]};
    end
    quo_s   = (a_neg_q ^ b_neg_q) ? -div_q : div_q;
    rem_s   = a_neg_q ? -div_r : div_r;
    div_res = op_q[1] ? rem_s : quo_s;
  end

`ifdef MULDIV_RESULT_REUSE_EN
  logic [XLEN-1:0] cache_a_q, cache_b_q, cache_lo_q, cache_hi_q;
  logic [2:0]      cache_cls_q;
  logic            cache_vld_q;
  logic            hit;
  logic [XLEN-1:0] hit_res;

  // A plain MUL only needs the low half, which is signedness-independent.
  always_comb begin
    hit = cache_vld_q && (a_i == cache_a_q) && (b_i == cache_b_q) &&
          (cache_cls_q[2] == is_div) &&
          ((cache_cls_q == cls) || (op_i == 3'd0));
    if (is_div) hit_res = op_i[1] ? cache_hi_q : cache_lo_q;
    else        hit_res = (op_i[1:0] == 2'd0) ? cache_lo_q : cache_hi_q;
  end
`else
  logic            hit;
  logic [XLEN-1:0] hit_res;
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
`ifdef MULDIV_RESULT_REUSE_EN
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_lo_q  <= '0;
      cache_hi_q  <= '0;
      cache_cls_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
`ifdef MULDIV_RESULT_REUSE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q    <= op_i[1:0];
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            a_q     <= a_mag;
            b_q     <= b_mag;
            if (fast || hit) begin
              result_q <= fast ? fast_res : hit_res;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else if (is_div) begin
              prod_q  <= {{XLEN{1'b0}}, a_mag};
              cnt_q   <= DIV_LAST;
              state_q <= S_DIV;
            end else begin
              prod_q  <= {{XLEN{1'b0}}, b_mag};
              cnt_q   <= MUL_LAST;
              state_q <= S_MUL;
            end
`ifdef MULDIV_RESULT_REUSE_EN
            // Any non-hit accept replaces the cached operands; the entry
            // becomes valid only when the iteration completes.
            if (!hit) begin
              cache_a_q   <= a_i;
              cache_b_q   <= b_i;
              cache_cls_q <= cls;
              cache_vld_q <= 1'b0;
            end
`endif
          end
        end
        S_MUL: begin
          prod_q <= mul_prod_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= mul_res;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
`ifdef MULDIV_RESULT_REUSE_EN
            cache_lo_q  <= mul_fin[XLEN-1:0];
            cache_hi_q  <= mul_fin[2*XLEN-1:XLEN];
            cache_vld_q <= 1'b1;
`endif
          end
        end
        S_DIV: begin
          prod_q <= {div_r, div_q};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= div_res;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
`ifdef MULDIV_RESULT_REUSE_EN
            cache_lo_q  <= quo_s;
            cache_hi_q  <= rem_s;
            cache_vld_q <= 1'b1;
`endif
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign stall_o  = (start_i && state_q == S_IDLE) || state_q == S_MUL || state_q == S_DIV;
  // A flush in the DONE cycle still kills the result pulse.
  assign valid_o  = valid_q && !flush_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, stall_o, valid_o;
  logic [31:0] result_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  ex_muldiv_unit #(.XLEN(32), .MUL_BPC(4), .DIV_BPC(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .ready_o(ready_o),
    .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // Starts an op at the current negedge (cycle 0) and returns at the negedge
  // where valid_o is seen. Operand inputs are scrambled after accept.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res,
                       output int stall_cyc, output logic stall_at_v);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    stall_cyc = stall_o ? 1 : 0;
    @(negedge clk_i);
    start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 200) begin
      if (stall_o) stall_cyc++;
      @(negedge clk_i);
      lat++;
    end
    res = result_o;
    stall_at_v = stall_o;
  endtask

  task automatic test_reset();
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_o); else pass_cnt++;
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'h0) $display("FAIL reset_result got %h want 0", result_o); else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat, sc; logic [31:0] r; logic sv;
    @(negedge clk_i); do_op(3'd0, 32'd7, 32'hFFFFFFFD, lat, r, sc, sv);
    total_cnt++; if (r !== 32'hFFFFFFEB) $display("FAIL mul_result got %h want ffffffeb", r); else pass_cnt++;
    total_cnt++; if (lat !== 9) $display("FAIL mul_latency got %0d want 9", lat); else pass_cnt++;
    total_cnt++; if (sc !== 9) $display("FAIL mul_stall_cycles got %0d want 9", sc); else pass_cnt++;
    total_cnt++; if (sv !== 1'b0) $display("FAIL mul_stall_at_valid got %b want 0", sv); else pass_cnt++;
    @(negedge clk_i); do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, sc, sv);
    total_cnt++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu_result got %h want fffffffe", r); else pass_cnt++;
    @(negedge clk_i); do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, sc, sv);
    total_cnt++; if (r !== 32'h00000000) $display("FAIL mulh_result got %h want 00000000", r); else pass_cnt++;
    @(negedge clk_i); do_op(3'd2, 32'hFFFFFFFF, 32'd2, lat, r, sc, sv);
    total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu_result got %h want ffffffff", r); else pass_cnt++;
  endtask

  task automatic test_div();
    int lat, sc; logic [31:0] r; logic sv;
    @(negedge clk_i); do_op(3'd5, 32'd100, 32'd7, lat, r, sc, sv);
    total_cnt++; if (r !== 32'd14) $display("FAIL divu_result got %h want 0000000e", r); else pass_cnt++;
    total_cnt++; if (lat !== 33) $display("FAIL divu_latency got %0d want 33", lat); else pass_cnt++;
    @(negedge clk_i); do_op(3'd7, 32'd100, 32'd7, lat, r, sc, sv);
    total_cnt++; if (r !== 32'd2) $display("FAIL remu_result got %h want 00000002", r); else pass_cnt++;
    @(negedge clk_i); do_op(3'd4, 32'hFFFFFF9C, 32'd7, lat, r, sc, sv);
    total_cnt++; if (r !== 32'hFFFFFFF2) $display("FAIL div_neg_result got %h want fffffff2", r); else pass_cnt++;
    @(negedge clk_i); do_op(3'd6, 32'hFFFFFF9C, 32'd7, lat, r, sc, sv);
    total_cnt++; if (r !== 32'hFFFFFFFE) $display("FAIL rem_neg_result got %h want fffffffe", r); else pass_cnt++;
  endtask

  task automatic test_fast_path();
    int lat, sc; logic [31:0] r; logic sv;
    @(negedge clk_i); do_op(3'd4, 32'd5, 32'd0, lat, r, sc, sv);
    total_cnt++; if (r !== 32'hFFFFFFFF || lat !== 1) $display("FAIL fast_div0 got %h/%0d want ffffffff/1", r, lat); else pass_cnt++;
    @(negedge clk_i); do_op(3'd7, 32'd5, 32'd0, lat, r, sc, sv);
    total_cnt++; if (r !== 32'd5 || lat !== 1) $display("FAIL fast_remu0 got %h/%0d want 00000005/1", r, lat); else pass_cnt++;
    @(negedge clk_i); do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, lat, r, sc, sv);
    total_cnt++; if (r !== 32'h80000000 || lat !== 1) $display("FAIL fast_div_ovf got %h/%0d want 80000000/1", r, lat); else pass_cnt++;
    @(negedge clk_i); do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, lat, r, sc, sv);
    total_cnt++; if (r !== 32'h0 || lat !== 1) $display("FAIL fast_rem_ovf got %h/%0d want 00000000/1", r, lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // One cycle after the valid pulse: pulse gone, idle, result held.
    @(negedge clk_i);
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL b2b_valid_pulse got %b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL b2b_ready got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'h0) $display("FAIL b2b_result_hold got %h want 00000000", result_o); else pass_cnt++;
  endtask

  task automatic test_abort(input bit use_rst);
    int lat, sc; logic [31:0] r; logic sv; bit saw_valid;
    saw_valid = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk_i); start_i = 1'b0;                       // cycle 1
    for (int i = 1; i < 10; i++) begin
      if (valid_o === 1'b1) saw_valid = 1'b1;
      @(negedge clk_i);
    end
    if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;          // cycle 10
    #1;
    if (valid_o === 1'b1) saw_valid = 1'b1;
    @(negedge clk_i);                                        // cycle 11
    rst_i = 1'b0; flush_i = 1'b0;
    total_cnt++; if (saw_valid) $display("FAIL abort%0d_no_valid got 1 want 0", use_rst); else pass_cnt++;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL abort%0d_ready got %b want 1", use_rst, ready_o); else pass_cnt++;
    if (use_rst) begin
      total_cnt++; if (result_o !== 32'h0) $display("FAIL abort_rst_result got %h want 0", result_o); else pass_cnt++;
    end
    do_op(3'd0, 32'd7, 32'd3, lat, r, sc, sv);
    total_cnt++; if (r !== 32'd21 || lat !== 9) $display("FAIL abort%0d_next_mul got %h/%0d want 00000015/9", use_rst, r, lat); else pass_cnt++;
  endtask

  task automatic test_reuse();
    int lat, sc, exp_lat; logic [31:0] r; logic sv;
`ifdef MULDIV_RESULT_REUSE_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    @(negedge clk_i); do_op(3'd4, 32'd100, 32'd7, lat, r, sc, sv);
    total_cnt++; if (r !== 32'd14 || lat !== 33) $display("FAIL reuse_first got %h/%0d want 0000000e/33", r, lat); else pass_cnt++;
    @(negedge clk_i); do_op(3'd6, 32'd100, 32'd7, lat, r, sc, sv);
    total_cnt++; if (r !== 32'd2 || lat !== exp_lat) $display("FAIL reuse_pair got %h/%0d want 00000002/%0d", r, lat, exp_lat); else pass_cnt++;
    @(negedge clk_i); do_op(3'd6, 32'd100, 32'd8, lat, r, sc, sv);
    total_cnt++; if (r !== 32'd4 || lat !== 33) $display("FAIL reuse_miss got %h/%0d want 00000004/33", r, lat); else pass_cnt++;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    test_reset();
    rst_i = 1'b0;
    test_mul();
    test_div();
    test_fast_path();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_reuse();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
